key_debounce_array: RTL and testbench



---
 rtl/key_debounce_array.sv | 184 ++++++++++++++++++
 tb/tb_key_debounce_array.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// key_debounce_array
//   Multi-channel push-button conditioner. Every channel is independent:
//   a two-flop synchroniser feeds a consecutive-stable-cycles debouncer.
//   A hold FSM then turns the debounced level into single-cycle strobes.
//
// Parameters
//   N_KEYS      number of channels (>= 1)
//   ACTIVE_LOW  1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//   DB_CYCLES   consecutive disagreeing cycles needed to accept a change (>= 2)
//   LONG_CYCLES held cycles from the press strobe to key_long (> DB_CYCLES)
//   RPT_CYCLES  auto-repeat period after key_long; 0 disables repeat
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw, asynchronous button pins
//   key_level    debounced state, 1 = pressed
//   key_press    1-cycle strobe when a press is accepted
//   key_release  1-cycle strobe when a release is accepted
//   key_long     1-cycle strobe once per hold, LONG_CYCLES after key_press
//   key_rpt      1-cycle strobe every RPT_CYCLES after key_long while held
//
// All outputs come straight from flops. There is no combinational path
// from key_in to any output.

module key_debounce_array #(
  parameter int N_KEYS      = 5,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000,
  parameter int RPT_CYCLES  = 20_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_rpt
);

  localparam int DB_W     = $clog2(DB_CYCLES);
  localparam int HOLD_W   = $clog2(LONG_CYCLES);
  localparam int RPT_W    = (RPT_CYCLES > 1) ? $clog2(RPT_CYCLES) : 1;
  localparam int RPT_LAST = (RPT_CYCLES > 0) ? RPT_CYCLES - 1 : 0;

  localparam logic [DB_W-1:0]   DB_LAST_C   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST_C  = RPT_W'(RPT_LAST);

  // Pin level when the button is not pressed.
  localparam logic RELEASED_PIN = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LONG = 2'd2
  } hold_state_e;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic              sync1_q, sync2_q;
    logic              raw;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    logic              rise_evt, fall_evt;
    hold_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic              press_q, release_q, long_q, rpt_q;
    logic              long_d, rpt_d;

    // Normalise to 1 = pressed regardless of pin polarity.
    assign raw = sync2_q ^ RELEASED_PIN;

    always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves
      // a variable unassigned and no latch is inferred.
      db_cnt_d   = db_cnt_q;
      level_d    = level_q;
      rise_evt   = 1'b0;
      fall_evt   = 1'b0;
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rpt_cnt_d  = rpt_cnt_q;
      long_d     = 1'b0;
      rpt_d      = 1'b0;

      // Debounce. Any cycle of agreement restarts the count.
      if (raw == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST_C) begin
        db_cnt_d = '0;
        level_d  = raw;
        rise_evt = raw;
        fall_evt = ~raw;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end

      // Hold FSM. An accepted fall wins over a long/repeat strobe due on the
      // same edge.
      unique case (state_q)
        ST_IDLE: begin
          if (rise_evt) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            rpt_cnt_d  = '0;
          end
        end
        ST_HOLD: begin
          if (fall_evt) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_LAST_C) begin
            long_d     = 1'b1;
            state_d    = ST_LONG;
            hold_cnt_d = '0;
            rpt_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (fall_evt) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
          end else if (RPT_CYCLES != 0) begin
            if (rpt_cnt_q == RPT_LAST_C) begin
              rpt_d     = 1'b1;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
          rpt_cnt_d  = '0;
        end
      endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the pre-edge values and the block order does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // Synchroniser resets to the released pin level. A button held
        // through reset therefore re-qualifies and gives a fresh press.
        sync1_q    <= RELEASED_PIN;
        sync2_q    <= RELEASED_PIN;
        db_cnt_q   <= '0;
        level_q    <= 1'b0;
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        rpt_cnt_q  <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        sync1_q    <= key_in[i];
        sync2_q    <= sync1_q;
        db_cnt_q   <= db_cnt_d;
        level_q    <= level_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rpt_cnt_q  <= rpt_cnt_d;
        press_q    <= rise_evt;
        release_q  <= fall_evt;
        long_q     <= long_d;
        rpt_q      <= rpt_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_rpt[i]     = rpt_q;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Testbench for key_debounce_array (N_KEYS=2, ACTIVE_LOW=1, DB_CYCLES=4,
// LONG_CYCLES=20, RPT_CYCLES=5).
// Stimulus is a table of {pin pattern, length} segments. When a segment
// table is built, the strobes it should cause are pushed to a scoreboard
// queue, each with its edge number counted from the first edge of the run.
// After every clock edge the bench pops the events due on that edge and
// compares all outputs at once.

module tb_key_debounce_array;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_in = 2'b11;
  logic [N-1:0] key_level, key_press, key_release, key_long, key_rpt;

  key_debounce_array #(
    .N_KEYS      (N),
    .ACTIVE_LOW  (1'b1),
    .DB_CYCLES   (4),
    .LONG_CYCLES (20),
    .RPT_CYCLES  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .key_rpt     (key_rpt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] pins;  // {ch1, ch0}; 0 = pressed
    int           len;
  } seg_t;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_RPT} ev_kind_e;

  typedef struct {
    int       t;
    int       ch;
    ev_kind_e kind;
  } ev_t;

  seg_t         seg_q[$];
  ev_t          exp_q[$];
  logic [N-1:0] exp_level = '0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(string name, logic [5*N-1:0] act, logic [5*N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got lvl/prs/rel/lng/rpt=%b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [5*N-1:0] outs();
    return {key_level, key_press, key_release, key_long, key_rpt};
  endfunction

  task automatic add_seg(logic [N-1:0] pins, int len);
    seg_t s;
    s.pins = pins;
    s.len  = len;
    seg_q.push_back(s);
  endtask

  // Events must be pushed in non-decreasing time order.
  task automatic expect_ev(int t, int ch, ev_kind_e kind);
    ev_t e;
    e.t    = t;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic check_edge(string tag, int k);
    logic [N-1:0] ep, er, el, et;
    ev_t          e;
    ep = '0; er = '0; el = '0; et = '0;
    while (exp_q.size() > 0 && exp_q[0].t <= k) begin
      e = exp_q.pop_front();
      case (e.kind)
        EV_PRESS:   begin ep[e.ch] = 1'b1; exp_level[e.ch] = 1'b1; end
        EV_RELEASE: begin er[e.ch] = 1'b1; exp_level[e.ch] = 1'b0; end
        EV_LONG:    el[e.ch] = 1'b1;
        default:    et[e.ch] = 1'b1;
      endcase
    end
    check($sformatf("%s edge %0d", tag, k), outs(), {exp_level, ep, er, el, et});
  endtask

  // Apply the segment table. Edge 0 is the first edge that samples the
  // first segment.
  task automatic run(string tag);
    seg_t s;
    int   k = 0;
    while (seg_q.size() > 0) begin
      s = seg_q.pop_front();
      for (int j = 0; j < s.len; j++) begin
        key_in = s.pins;
        @(posedge clk);
        #1;
        check_edge(tag, k);
        k++;
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s leftover events: got %0d pending, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Hold reset for some cycles with the given pins, checking that all
  // outputs stay 0. Release just after an edge.
  task automatic do_reset(int cycles, logic [N-1:0] pins);
    rst_n     = 1'b0;
    key_in    = pins;
    exp_level = '0;
    for (int j = 0; j < cycles; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset cycle %0d", j), outs(), '0);
    end
    rst_n = 1'b1;
  endtask

  // Channel 0 held 40 cycles, then released. The repeat due at edge 45
  // coincides with the accepted release and must be suppressed.
  task automatic load_long_hold();
    add_seg(2'b10, 40);
    add_seg(2'b11, 15);
    expect_ev(5,  0, EV_PRESS);
    expect_ev(25, 0, EV_LONG);
    expect_ev(30, 0, EV_RPT);
    expect_ev(35, 0, EV_RPT);
    expect_ev(40, 0, EV_RPT);
    expect_ev(45, 0, EV_RELEASE);
  endtask

  initial begin
    // Reset with both pins released, then 50 quiet cycles.
    do_reset(5, 2'b11);
    add_seg(2'b11, 50);
    run("idle");

    // Press, long press, repeat, release on channel 0 only.
    load_long_hold();
    run("hold");

    // Bounce: 3-low glitches never qualify; 4 low cycles is the minimum.
    add_seg(2'b10, 3);
    add_seg(2'b11, 1);
    add_seg(2'b10, 3);
    add_seg(2'b11, 5);
    add_seg(2'b10, 4);
    add_seg(2'b11, 15);
    expect_ev(17, 0, EV_PRESS);
    expect_ev(21, 0, EV_RELEASE);
    run("bounce");

    // Release accepted on the very edge key_long is due: no key_long.
    add_seg(2'b10, 20);
    add_seg(2'b11, 15);
    expect_ev(5,  0, EV_PRESS);
    expect_ev(25, 0, EV_RELEASE);
    run("long_suppress");

    // Both channels pressed together; ch1 released 2 cycles before ch0.
    add_seg(2'b00, 30);
    add_seg(2'b10, 2);
    add_seg(2'b11, 15);
    expect_ev(5,  0, EV_PRESS);
    expect_ev(5,  1, EV_PRESS);
    expect_ev(25, 0, EV_LONG);
    expect_ev(25, 1, EV_LONG);
    expect_ev(30, 0, EV_RPT);
    expect_ev(30, 1, EV_RPT);
    expect_ev(35, 1, EV_RELEASE);
    expect_ev(35, 0, EV_RPT);
    expect_ev(37, 0, EV_RELEASE);
    run("dual");

    // Reach LONG on ch0, then assert reset between edges while held.
    add_seg(2'b10, 28);
    expect_ev(5,  0, EV_PRESS);
    expect_ev(25, 0, EV_LONG);
    run("pre_reset");
    rst_n = 1'b0;
    #1;
    check("async reset", outs(), '0);
    do_reset(3, 2'b10);

    // Button still held after reset release: fresh press and long press.
    load_long_hold();
    run("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
